principal_search_sequencer: RTL

PRINCIPAL_SEARCH_SEQUENCER -- requirements
Module: principal_search_sequencer

---
 rtl/principal_search_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/principal_search_sequencer.sv
// ============================================================================
// Module   : principal_search_sequencer
// Purpose  : Time-multiplexes N_MACH search sub-machines. One machine runs at
//            a time. Its state_control code picks which machine runs next
//            (stay / next / previous / home). A settle gap with a restart
//            pulse is inserted at every switch. Forward wraps are counted
//            as laps.
// Options  : `define SEARCH_TIMEOUT_EN adds a dwell-timeout counter. When the
//            running machine has dwelt TIMEOUT_CYC RUN cycles with code 00,
//            the counter forces a "next" transition.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module principal_search_sequencer #(
   parameter int N_MACH      = 4,
   parameter int MV_W        = 4,
   parameter int SETTLE_CYC  = 1,
   parameter int TIMEOUT_CYC = 255,
   parameter int LAP_W       = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic [2*N_MACH-1:0]        sc_bus,
   input  logic [MV_W*N_MACH-1:0]     mv_bus,
   output logic [MV_W-1:0]            movement_sel,
   output logic [$clog2(N_MACH)-1:0]  active_idx,
   output logic [N_MACH-1:0]          mach_en,
   output logic [N_MACH-1:0]          mach_start,
   output logic [LAP_W-1:0]           lap_count,
   output logic                       timeout_flag
);

   localparam int                IDX_W         = $clog2(N_MACH);
   localparam logic [IDX_W-1:0]  C_LAST        = IDX_W'(N_MACH - 1);
   localparam logic [3:0]        C_SETTLE_LAST = 4'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_RUN    = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IDX_W-1:0]    r_idx;
   logic [IDX_W-1:0]    w_idx_nxt;
   logic [IDX_W-1:0]    w_idx_fwd;
   logic [IDX_W-1:0]    w_idx_back;
   logic [3:0]          r_settle_cnt;
   logic [LAP_W-1:0]    r_lap;
   logic                w_lap_inc;
   logic [1:0]          w_sc;
   logic [MV_W-1:0]     w_mv;
   logic [N_MACH-1:0]   w_onehot;
   logic                w_timeout;

   // Select the state_control and movement slices of the active machine
   always_comb begin
      w_sc = 2'b00;
      w_mv = '0;
      for (int i = 0; i < N_MACH; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_sc = sc_bus[2*i +: 2];
            w_mv = mv_bus[MV_W*i +: MV_W];
         end
      end
   end

   assign w_idx_fwd  = (r_idx == C_LAST)     ? '0     : r_idx + 1'b1;
   assign w_idx_back = (r_idx == '0)         ? C_LAST : r_idx - 1'b1;
   assign w_onehot   = {{(N_MACH-1){1'b0}}, 1'b1} << r_idx;

`ifdef SEARCH_TIMEOUT_EN
   localparam logic [16:0] C_TIMEOUT = 17'(TIMEOUT_CYC);

   logic [15:0] r_dwell;

   // Timeout fires on the RUN cycle that completes the dwell budget
   assign w_timeout = (r_state == S_RUN) && enable && (w_sc == 2'b00) &&
                      (({1'b0, r_dwell} + 17'd1) == C_TIMEOUT);

   // Dwell counter: counts RUN cycles spent on code 00; cleared outside RUN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dwell <= '0;
      end else if ((r_state == S_RUN) && (w_state_nxt == S_RUN)) begin
         r_dwell <= r_dwell + 16'd1;
      end else begin
         r_dwell <= '0;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   // Next-state, next-index and lap-increment decision
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_lap_inc   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable) begin
               w_state_nxt = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (!enable) begin
               w_state_nxt = S_IDLE;
            end else if (r_settle_cnt == C_SETTLE_LAST) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (!enable) begin
               w_state_nxt = S_IDLE;
            end else if (w_sc != 2'b00) begin
               w_state_nxt = S_SETTLE;
               case (w_sc)
                  2'b01: begin
                     w_idx_nxt = w_idx_fwd;
                     w_lap_inc = (r_idx == C_LAST);
                  end
                  2'b10:   w_idx_nxt = w_idx_back;
                  default: w_idx_nxt = '0;
               endcase
            end else if (w_timeout) begin
               w_state_nxt = S_SETTLE;
               w_idx_nxt   = w_idx_fwd;
               w_lap_inc   = (r_idx == C_LAST);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, index, settle counter and saturating lap counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_settle_cnt <= '0;
         r_lap        <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         if ((r_state == S_SETTLE) && (w_state_nxt == S_SETTLE)) begin
            r_settle_cnt <= r_settle_cnt + 4'd1;
         end else begin
            r_settle_cnt <= '0;
         end
         if (w_lap_inc && (r_lap != {LAP_W{1'b1}})) begin
            r_lap <= r_lap + 1'b1;
         end
      end
   end

   // Outputs derive from registered state, so reset clears them immediately
   always_comb begin
      mach_en      = (r_state == S_RUN) ? w_onehot : '0;
      movement_sel = (r_state == S_RUN) ? w_mv     : '0;
      mach_start   = ((r_state == S_SETTLE) && (r_settle_cnt == 4'd0)) ? w_onehot : '0;
      active_idx   = r_idx;
      lap_count    = r_lap;
      timeout_flag = w_timeout;
   end

endmodule

`default_nettype wire
